// File: rtl/instruction_fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer: the fetch state
// encoding, the instruction size used for sequential PC advance, and the
// alignment mask used to validate redirect targets.
// -----------------------------------------------------------------------------
package instruction_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,  // request presented, address = pc
    WAIT   = 2'd1,  // one request outstanding, awaiting response
    HOLD   = 2'd2,  // fetched word presented to decode
    HALTED = 2'd3   // misaligned redirect seen; only reset leaves
  } fetch_state_e;

  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK        = 32'h0000_0003;

  function automatic logic is_aligned(input logic [31:0] address);
    return (address & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer
// Owns the architectural PC. Issues one instruction-memory read at a time,
// presents each fetched word with its PC to decode, and applies redirects from
// the jump/branch units, cancelling any in-flight or held fetch. A redirect to
// a target that is not 4-byte aligned halts fetch and raises a sticky error.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   redirect_valid/_target      resolved control transfer and its new PC
//   imem_request_*              read request (valid/ready) and word address
//   imem_response_*             returned instruction word
//   instruction_valid/_ready    handshake to decode
//   instruction                 held instruction word
//   instruction_program_counter PC of the held instruction
//   misaligned_jump_error       sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_request_valid,
  input  logic        imem_request_ready,
  output logic [31:0] imem_request_address,
  input  logic        imem_response_valid,
  input  logic [31:0] imem_response_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_program_counter,
  output logic        misaligned_jump_error
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         discard, discard_next;
  logic         error_next;
  logic         capture;
  logic         request_fire;
  logic         redirect_ok;
  logic         redirect_bad;

  // The request valid register mirrors "state is FETCH" except while reset is
  // held, so valid reads 0 during reset and rises the first cycle after.
  assign request_fire = imem_request_valid & imem_request_ready;
  assign redirect_ok  = redirect_valid &  is_aligned(redirect_target);
  assign redirect_bad = redirect_valid & ~is_aligned(redirect_target);

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    error_next   = misaligned_jump_error;
    capture      = 1'b0;

    unique case (state)
      FETCH: begin
        if (redirect_ok) pc_next = redirect_target;
        if (request_fire) begin
          state_next   = WAIT;
          // The request just issued fetches the old PC; drop its response.
          discard_next = redirect_ok;
        end
      end

      WAIT: begin
        if (redirect_ok) begin
          pc_next = redirect_target;
          if (imem_response_valid) begin
            // Outstanding response arrives with the redirect: drop it now.
            state_next   = FETCH;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end else if (imem_response_valid) begin
          discard_next = 1'b0;
          if (discard) begin
            state_next = FETCH;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        // A redirect wins over the sequential advance; a same-cycle accept
        // still counts as consumed by decode.
        if (redirect_ok) begin
          pc_next    = redirect_target;
          state_next = FETCH;
        end else if (instruction_ready) begin
          pc_next    = pc + INSTRUCTION_BYTES;
          state_next = FETCH;
        end
      end

      HALTED: ;

      default: state_next = HALTED;
    endcase

    if (redirect_bad) begin
      error_next   = 1'b1;
      state_next   = HALTED;
      discard_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state                       <= FETCH;
      pc                          <= RESET_VECTOR;
      discard                     <= 1'b0;
      misaligned_jump_error       <= 1'b0;
      imem_request_valid          <= 1'b0;
      instruction                 <= 32'h0;
      instruction_program_counter <= 32'h0;
    end else begin
      state                 <= state_next;
      pc                    <= pc_next;
      discard               <= discard_next;
      misaligned_jump_error <= error_next;
      imem_request_valid    <= (state_next == FETCH);
      if (capture) begin
        instruction                 <= imem_response_data;
        instruction_program_counter <= pc;
      end
    end
  end

  assign imem_request_address = pc;
  assign instruction_valid    = (state == HOLD);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_sequencer
// Directed stimulus with a scoreboard: stimulus pushes the expected request
// addresses and decoded instructions into queues; a monitor pops and compares
// on every request handshake and every decode acceptance. A small memory
// responder returns word_for(address) a programmable number of cycles after
// each request handshake.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_instr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_request_valid;
  logic        imem_request_ready;
  logic [31:0] imem_request_address;
  logic        imem_response_valid;
  logic [31:0] imem_response_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_program_counter;
  logic        misaligned_jump_error;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int mem_latency = 1;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];
  int          accept_cycles[$];

  instruction_fetch_sequencer dut (
    .clk                         (clk),
    .reset                       (reset),
    .redirect_valid              (redirect_valid),
    .redirect_target             (redirect_target),
    .imem_request_valid          (imem_request_valid),
    .imem_request_ready          (imem_request_ready),
    .imem_request_address        (imem_request_address),
    .imem_response_valid         (imem_response_valid),
    .imem_response_data          (imem_response_data),
    .instruction_valid           (instruction_valid),
    .instruction_ready           (instruction_ready),
    .instruction                 (instruction),
    .instruction_program_counter (instruction_program_counter),
    .misaligned_jump_error       (misaligned_jump_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] word_for(input logic [31:0] address);
    return {address[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr_drain(input string name);
    int n = 0;
    while (exp_addr_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic wait_instr_drain(input string name);
    int n = 0;
    while (exp_instr_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(exp_instr_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instruction_valid && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, instruction_valid}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
  endtask

  // Memory responder: one outstanding read, answered mem_latency cycles later.
  initial begin : memory
    logic [31:0] addr;
    imem_response_valid = 1'b0;
    imem_response_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_request_valid && imem_request_ready) begin
        addr = imem_request_address;
        repeat (mem_latency) @(posedge clk);
        #1;
        imem_response_valid = 1'b1;
        imem_response_data  = word_for(addr);
        @(posedge clk);
        #1;
        imem_response_valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (imem_request_valid && imem_request_ready) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_request", imem_request_address, 32'hDEAD_BEEF);
      end else begin
        check("request_address", imem_request_address, exp_addr_q.pop_front());
      end
    end
    if (instruction_valid && instruction_ready) begin
      accept_cycles.push_back(cycle);
      if (exp_instr_q.size() == 0) begin
        check("unexpected_instruction", instruction_program_counter, 32'hDEAD_BEEF);
      end else begin
        exp_instr_t e;
        e = exp_instr_q.pop_front();
        check("instruction_pc", instruction_program_counter, e.pc);
        check("instruction_word", instruction, e.word);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset              = 1'b1;
    redirect_valid     = 1'b0;
    redirect_target    = 32'h0;
    imem_request_ready = 1'b0;
    instruction_ready  = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_request_valid", {31'd0, imem_request_valid}, 32'd0);
    check("reset_address", imem_request_address, 32'h0);
    check("reset_instruction_valid", {31'd0, instruction_valid}, 32'd0);
    check("reset_instruction", instruction, 32'h0);
    check("reset_instruction_pc", instruction_program_counter, 32'h0);
    check("reset_error", {31'd0, misaligned_jump_error}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    @(negedge clk);
    check("first_request_valid", {31'd0, imem_request_valid}, 32'd1);
    check("first_request_address", imem_request_address, 32'h0);

    // Zero-wait streaming: 0x0, 0x4, 0x8, one instruction per 3 cycles
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_instr_q.push_back('{pc: 32'h0, word: 32'h0000_0013});
    exp_instr_q.push_back('{pc: 32'h4, word: 32'h0000_0413});
    exp_instr_q.push_back('{pc: 32'h8, word: 32'h0000_0813});
    @(posedge clk);
    #1;
    accept_cycles.delete();
    imem_request_ready = 1'b1;
    instruction_ready  = 1'b1;
    wait_addr_drain("stream_requests");
    imem_request_ready = 1'b0;
    wait_instr_drain("stream_instructions");
    instruction_ready = 1'b0;
    if (accept_cycles.size() >= 3) begin
      check("stream_spacing_1", 32'(accept_cycles[1] - accept_cycles[0]), 32'd3);
      check("stream_spacing_2", 32'(accept_cycles[2] - accept_cycles[1]), 32'd3);
    end else begin
      check("stream_accept_count", 32'(accept_cycles.size()), 32'd3);
    end
    check("after_stream_address", imem_request_address, 32'hC);

    // Decode stall in HOLD: word and PC stable, no request issued
    exp_addr_q.push_back(32'hC);
    imem_request_ready = 1'b1;
    wait_valid("stall_reach_hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_instruction", instruction, 32'h0000_0C13);
      check("stall_pc", instruction_program_counter, 32'hC);
      check("stall_no_request", {31'd0, imem_request_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    imem_request_ready = 1'b0;
    exp_instr_q.push_back('{pc: 32'hC, word: 32'h0000_0C13});
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    wait_instr_drain("stall_release");

    // Redirect while WAIT, response two cycles later is dropped
    mem_latency = 3;
    exp_addr_q.push_back(32'h10);
    imem_request_ready = 1'b1;
    wait_addr_drain("wait_old_request");
    exp_addr_q.push_back(32'h100);
    exp_instr_q.push_back('{pc: 32'h100, word: 32'h0001_0013});
    redirect(32'h0000_0100);
    mem_latency       = 1;
    instruction_ready = 1'b1;
    wait_addr_drain("wait_redirect_request");
    imem_request_ready = 1'b0;
    wait_instr_drain("wait_redirect_instruction");
    instruction_ready = 1'b0;

    // Redirect in HOLD with same-cycle accept: consumed once, next fetch 0x200
    exp_addr_q.push_back(32'h104);
    imem_request_ready = 1'b1;
    wait_addr_drain("hold_request");
    imem_request_ready = 1'b0;
    wait_valid("hold_reach_hold");
    exp_instr_q.push_back('{pc: 32'h104, word: 32'h0001_0413});
    exp_addr_q.push_back(32'h200);
    instruction_ready = 1'b1;
    redirect(32'h0000_0200);
    instruction_ready = 1'b0;
    @(negedge clk);
    check("hold_redirect_valid_drop", {31'd0, instruction_valid}, 32'd0);
    check("hold_redirect_address", imem_request_address, 32'h200);
    wait_instr_drain("hold_accept_once");
    @(posedge clk);
    #1 imem_request_ready = 1'b1;
    wait_addr_drain("hold_target_request");
    imem_request_ready = 1'b0;
    wait_valid("target_reach_hold");
    check("target_pc", instruction_program_counter, 32'h200);

    // Redirect drops held 0x200 word; wrap FFFF_FFFC -> 0000_0000
    redirect(32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_held_dropped", {31'd0, instruction_valid}, 32'd0);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_instr_q.push_back('{pc: 32'hFFFF_FFFC, word: 32'hFFFF_FC13});
    exp_instr_q.push_back('{pc: 32'h0, word: 32'h0000_0013});
    @(posedge clk);
    #1;
    imem_request_ready = 1'b1;
    instruction_ready  = 1'b1;
    wait_addr_drain("wrap_requests");
    imem_request_ready = 1'b0;
    wait_instr_drain("wrap_instructions");
    instruction_ready = 1'b0;
    check("wrap_next_address", imem_request_address, 32'h4);

    // Misaligned redirect halts fetch until reset
    redirect(32'h0000_0102);
    @(negedge clk);
    check("misaligned_error", {31'd0, misaligned_jump_error}, 32'd1);
    check("misaligned_request_valid", {31'd0, imem_request_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect(32'h0000_0300);
    imem_request_ready = 1'b1;
    instruction_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("halted_request_valid", {31'd0, imem_request_valid}, 32'd0);
      check("halted_error_sticky", {31'd0, misaligned_jump_error}, 32'd1);
    end
    @(posedge clk);
    #1;
    imem_request_ready = 1'b0;
    instruction_ready  = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rereset_error", {31'd0, misaligned_jump_error}, 32'd0);
    check("rereset_address", imem_request_address, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_addr_q.push_back(32'h0);
    exp_instr_q.push_back('{pc: 32'h0, word: 32'h0000_0013});
    imem_request_ready = 1'b1;
    instruction_ready  = 1'b1;
    wait_addr_drain("restart_request");
    imem_request_ready = 1'b0;
    wait_instr_drain("restart_instruction");
    instruction_ready = 1'b0;
    repeat (3) tick();

    check("leftover_requests", 32'(exp_addr_q.size()), 32'd0);
    check("leftover_instructions", 32'(exp_instr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
